mult_div_unit: RTL and testbench

//  E-stage multi-cycle multiply/divide unit holding the architectural HI/LO registers.

---
 rtl/mult_div_unit_pkg.sv | 34 +++
 rtl/mult_div_unit.sv | 144 ++++++++++++++
 tb/tb_mult_div_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit_pkg
//  Description : Op codes, FSM states and op-class helpers for mult_div_unit.
//  Revision    : 1.0  initial release
// ============================================================================
package mult_div_unit_pkg;

    localparam int MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Ops that occupy the unit for several cycles.
    function automatic logic is_start(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : E-stage multi-cycle multiply/divide unit owning HI/LO.
//  Revision    : 1.0  initial release
// ============================================================================
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    output logic               busy,
    output logic               start_busy,
    output logic [31:0]        hi,
    output logic [31:0]        lo
);

    localparam int                c_CNT_W     = $clog2(DIV_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);

    md_state_e          r_state;
    md_state_e          w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_start;
    logic               w_wb;
    logic [31:0]        r_temp_hi;
    logic [31:0]        r_temp_lo;
    logic               r_wb_en;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    // ---------------- arithmetic ----------------
    logic signed [63:0] w_smul;
    logic        [63:0] w_umul;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic signed [31:0] w_sdivisor;
    logic        [31:0] w_udivisor;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;
    logic        [31:0] w_uq;
    logic        [31:0] w_ur;
    logic        [63:0] w_res;

    assign w_smul     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_umul     = {32'd0, a} * {32'd0, b};
    assign w_div_zero = (b == 32'd0);
    assign w_div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    // Dividing by 1 instead of -1 yields the architected 0x80000000 / 0 result
    // for the overflow case and keeps the divider away from a trapping operand.
    assign w_sdivisor = (w_div_zero || w_div_ovf) ? 32'sd1 : $signed(b);
    assign w_udivisor = w_div_zero ? 32'd1 : b;
    assign w_sq       = $signed(a) / w_sdivisor;
    assign w_sr       = $signed(a) % w_sdivisor;
    assign w_uq       = a / w_udivisor;
    assign w_ur       = a % w_udivisor;

    always_comb begin
        w_res = 64'd0;
        case (md_op)
            MD_MULT:  w_res = w_smul;
            MD_MULTU: w_res = w_umul;
            MD_DIV:   w_res = {w_sr, w_sq};
            MD_DIVU:  w_res = {w_ur, w_uq};
            default:  w_res = 64'd0;
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        w_wb        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (is_start(md_op)) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = is_div(md_op) ? c_DIV_LOAD : c_MULT_LOAD;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == c_CNT_W'(1)) begin
                    w_wb        = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_temp_hi <= 32'd0;
            r_temp_lo <= 32'd0;
            r_wb_en   <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_start) begin
                r_temp_hi <= w_res[63:32];
                r_temp_lo <= w_res[31:0];
                r_wb_en   <= !(is_div(md_op) && w_div_zero);
            end
            if (w_wb) begin
                if (r_wb_en) begin
                    r_hi <= r_temp_hi;
                    r_lo <= r_temp_lo;
                end
            end else if (r_state == ST_IDLE) begin
                if (md_op == MD_MTHI) r_hi <= a;
                if (md_op == MD_MTLO) r_lo <= a;
            end
        end
    end

    assign busy       = (r_state == ST_RUN);
    assign start_busy = busy | is_start(md_op);
    assign hi         = r_hi;
    assign lo         = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Directed self-checking bench for mult_div_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;

    localparam logic [2:0] c_NONE  = 3'd0;
    localparam logic [2:0] c_MULT  = 3'd1;
    localparam logic [2:0] c_MULTU = 3'd2;
    localparam logic [2:0] c_DIV   = 3'd3;
    localparam logic [2:0] c_DIVU  = 3'd4;
    localparam logic [2:0] c_MTHI  = 3'd5;
    localparam logic [2:0] c_MTLO  = 3'd6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        start_busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;
    int n_illegal = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .md_op(md_op), .a(a), .b(b),
        .busy(busy), .start_busy(start_busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Flags any op presented while the unit is busy (hazard-unit contract).
    always @(negedge clk) begin
        if (!reset && busy && md_op != c_NONE) n_illegal++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one op for a single cycle, then counts the busy cycles that follow.
    task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                         output int cycles, output logic sb);
        md_op = op; a = va; b = vb;
        #1 sb = start_busy;
        tick();
        md_op = c_NONE; a = 32'd0; b = 32'd0;
        cycles = 0;
        while (busy && cycles < 64) begin
            cycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want 00000000", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want 00000000", lo); end
        n_cmp++; if (start_busy !== 1'b0) begin n_err++; $display("FAIL reset_start_busy: got %b want 0", start_busy); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mult();
        int cyc; logic sb;
        issue(c_MULT, 32'hFFFF_FFFD, 32'd5, cyc, sb);
        n_cmp++; if (cyc != 5) begin n_err++; $display("FAIL mult_busy_len: got %0d want 5", cyc); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFF1) begin n_err++; $display("FAIL mult_lo: got %h want fffffff1", lo); end
    endtask

    task automatic test_multu();
        int cyc; logic sb;
        issue(c_MULTU, 32'hFFFF_FFFF, 32'd2, cyc, sb);
        n_cmp++; if (sb !== 1'b1) begin n_err++; $display("FAIL multu_start_busy: got %b want 1", sb); end
        n_cmp++; if (cyc != 5) begin n_err++; $display("FAIL multu_busy_len: got %0d want 5", cyc); end
        n_cmp++; if (hi !== 32'h0000_0001) begin n_err++; $display("FAIL multu_hi: got %h want 00000001", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
    endtask

    task automatic test_div();
        int cyc; logic sb;
        issue(c_DIV, 32'hFFFF_FFF9, 32'd2, cyc, sb);
        n_cmp++; if (cyc != 10) begin n_err++; $display("FAIL div_busy_len: got %0d want 10", cyc); end
        n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        issue(c_DIVU, 32'd7, 32'd0, cyc, sb);
        n_cmp++; if (cyc != 10) begin n_err++; $display("FAIL divzero_busy_len: got %0d want 10", cyc); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divzero_hi: got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL divzero_lo: got %h want fffffffd", lo); end
    endtask

    task automatic test_div_corner();
        int cyc; logic sb;
        issue(c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, sb);
        n_cmp++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        n_cmp++; if (hi !== 32'h0000_0000) begin n_err++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
        issue(c_DIVU, 32'hFFFF_FFFF, 32'd10, cyc, sb);
        n_cmp++; if (lo !== 32'h1999_9999) begin n_err++; $display("FAIL divu_lo: got %h want 19999999", lo); end
        n_cmp++; if (hi !== 32'h0000_0005) begin n_err++; $display("FAIL divu_hi: got %h want 00000005", hi); end
    endtask

    task automatic test_mthi_mtlo();
        md_op = c_MTHI; a = 32'h1234_5678;
        #1;
        n_cmp++; if (start_busy !== 1'b0) begin n_err++; $display("FAIL mthi_start_busy: got %b want 0", start_busy); end
        tick();
        n_cmp++; if (hi !== 32'h1234_5678) begin n_err++; $display("FAIL mthi_hi: got %h want 12345678", hi); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy: got %b want 0", busy); end
        md_op = c_MTLO; a = 32'h9ABC_DEF0;
        tick();
        md_op = c_NONE; a = 32'd0;
        n_cmp++; if (lo !== 32'h9ABC_DEF0) begin n_err++; $display("FAIL mtlo_lo: got %h want 9abcdef0", lo); end
        n_cmp++; if (hi !== 32'h1234_5678) begin n_err++; $display("FAIL mtlo_hi_kept: got %h want 12345678", hi); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mtlo_busy: got %b want 0", busy); end
    endtask

    task automatic test_op_while_busy();
        int cyc;
        md_op = c_MULT; a = 32'd7; b = 32'd6;
        tick();
        md_op = c_NONE; a = 32'd0; b = 32'd0;
        tick();
        n_cmp++; if (hi !== 32'h1234_5678) begin n_err++; $display("FAIL busy_hi_held: got %h want 12345678", hi); end
        md_op = c_MTHI; a = 32'hDEAD_BEEF;
        tick();
        md_op = c_NONE; a = 32'd0;
        cyc = 0;
        while (busy && cyc < 64) begin cyc++; tick(); end
        n_cmp++; if (cyc != 3) begin n_err++; $display("FAIL busy_tail_len: got %0d want 3", cyc); end
        n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL busy_mthi_hi: got %h want 00000000", hi); end
        n_cmp++; if (lo !== 32'd42) begin n_err++; $display("FAIL busy_mthi_lo: got %h want 0000002a", lo); end
        n_cmp++; if (n_illegal != 1) begin n_err++; $display("FAIL busy_op_flagged: got %0d want 1", n_illegal); end
    endtask

    task automatic test_back_to_back();
        int cyc; logic sb;
        issue(c_MULTU, 32'd3, 32'd4, cyc, sb);
        n_cmp++; if (lo !== 32'd12) begin n_err++; $display("FAIL b2b_first_lo: got %h want 0000000c", lo); end
        issue(c_DIV, 32'd100, 32'd7, cyc, sb);
        n_cmp++; if (cyc != 10) begin n_err++; $display("FAIL b2b_busy_len: got %0d want 10", cyc); end
        n_cmp++; if (lo !== 32'd14) begin n_err++; $display("FAIL b2b_lo: got %h want 0000000e", lo); end
        n_cmp++; if (hi !== 32'd2) begin n_err++; $display("FAIL b2b_hi: got %h want 00000002", hi); end
    endtask

    task automatic test_reset_in_run();
        int cyc; logic sb;
        md_op = c_DIV; a = 32'd100; b = 32'd3;
        tick();
        md_op = c_NONE; a = 32'd0; b = 32'd0;
        tick(); tick(); tick();
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL abort_hi: got %h want 00000000", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL abort_lo: got %h want 00000000", lo); end
        tick();
        reset = 1'b0;
        repeat (10) tick();
        n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL abort_no_wb: got %h want 00000000", lo); end
        issue(c_MULT, 32'd2, 32'd3, cyc, sb);
        n_cmp++; if (cyc != 5) begin n_err++; $display("FAIL post_abort_len: got %0d want 5", cyc); end
        n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL post_abort_hi: got %h want 00000000", hi); end
        n_cmp++; if (lo !== 32'd6) begin n_err++; $display("FAIL post_abort_lo: got %h want 00000006", lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_corner();
        test_mthi_mtlo();
        test_op_while_busy();
        test_back_to_back();
        test_reset_in_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
